des_core: RTL and testbench

- Iterative DES encryption core computing one Feistel round per clock.
- Free-running: samples plaintext and key, runs 16 rounds, registers the ciphertext, then immediately samples the next block (17 clocks per block).
- Exposes internal round/key-schedule state for debug and verification.
- Sits as a leaf crypto engine under any block that supplies stable DIN/key.

---
 rtl/des_core.sv | 240 ++++++++++++++++++++++++
 tb/tb_des_core.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/des_core.sv
// Iterative DES encryption core, one Feistel round per clock, 17 clocks per block.
// Optional DES_DONE_EN adds a one-cycle 'done' pulse while round_index is 0 after a block completes.
//
// round_index | meaning
// 0           | load IP(DIN) and PC1(key); DOUT holds
// 1..15       | Feistel round r; key schedule advances
// 16          | final round; DOUT <= FP(R16||L16), counter wraps to 0
module des_core (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [0:63] DIN,
   input  logic [0:63] key,
   output logic [0:63] DOUT,
   output logic [0:63] round_in,
   output logic [0:55] curr_key,
   output logic [0:55] next_key,
   output logic [0:47] round_key,
   output logic        shift_out,
`ifdef DES_DONE_EN
   output logic        done,
`endif
   output logic [4:0]  round_index_out
);

   localparam int IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10,  2,
      60, 52, 44, 36, 28, 20, 12,  4,
      62, 54, 46, 38, 30, 22, 14,  6,
      64, 56, 48, 40, 32, 24, 16,  8,
      57, 49, 41, 33, 25, 17,  9,  1,
      59, 51, 43, 35, 27, 19, 11,  3,
      61, 53, 45, 37, 29, 21, 13,  5,
      63, 55, 47, 39, 31, 23, 15,  7
   };

   localparam int FP_T [64] = '{
      40,  8, 48, 16, 56, 24, 64, 32,
      39,  7, 47, 15, 55, 23, 63, 31,
      38,  6, 46, 14, 54, 22, 62, 30,
      37,  5, 45, 13, 53, 21, 61, 29,
      36,  4, 44, 12, 52, 20, 60, 28,
      35,  3, 43, 11, 51, 19, 59, 27,
      34,  2, 42, 10, 50, 18, 58, 26,
      33,  1, 41,  9, 49, 17, 57, 25
   };

   localparam int E_T [48] = '{
      32,  1,  2,  3,  4,  5,
       4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13,
      12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21,
      20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29,
      28, 29, 30, 31, 32,  1
   };

   localparam int P_T [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,
       1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9,
      19, 13, 30,  6, 22, 11,  4, 25
   };

   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   // Each S-box is stored row-major: entry = S[row*16 + col], row = b1b6, col = b2..b5.
   localparam int SBOX [8][64] = '{
      '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
      '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
      '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
      '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
      '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
      '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
      '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
      '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
   };

   logic [4:0]  round_idx_q;
   logic [0:63] state_q;
   logic [0:55] key_q;
   logic [0:63] dout_q;

   logic [0:63] ip_w;
   logic [0:55] pc1_w;
   logic [0:55] next_key_w;
   logic [0:47] round_key_w;
   logic [0:47] e_w;
   logic [0:47] sin_w;
   logic [0:31] s_w;
   logic [0:31] p_w;
   logic [0:63] round_d;
   logic [0:63] swap_w;
   logic [0:63] fp_w;
   logic        shift_w;

   // Parity bits of the key are discarded by PC1.
   logic unused_parity;
   assign unused_parity = ^{key[7], key[15], key[23], key[31],
                            key[39], key[47], key[55], key[63]};

   for (genvar g = 0; g < 64; g++) begin : g_ip
      assign ip_w[g] = DIN[IP_T[g]-1];
   end

   for (genvar g = 0; g < 56; g++) begin : g_pc1
      assign pc1_w[g] = key[PC1_T[g]-1];
   end

   assign shift_w = (round_idx_q == 5'd1) || (round_idx_q == 5'd2) ||
                    (round_idx_q == 5'd9) || (round_idx_q == 5'd16);

   always_comb begin
      next_key_w = '0;
      if (shift_w) begin
         next_key_w[0:27]  = {key_q[1:27],  key_q[0]};
         next_key_w[28:55] = {key_q[29:55], key_q[28]};
      end else begin
         next_key_w[0:27]  = {key_q[2:27],  key_q[0:1]};
         next_key_w[28:55] = {key_q[30:55], key_q[28:29]};
      end
   end

   for (genvar g = 0; g < 48; g++) begin : g_pc2
      assign round_key_w[g] = next_key_w[PC2_T[g]-1];
   end

   for (genvar g = 0; g < 48; g++) begin : g_e
      assign e_w[g] = state_q[32 + E_T[g] - 1];
   end

   assign sin_w = e_w ^ round_key_w;

   for (genvar g = 0; g < 8; g++) begin : g_sbox
      logic [5:0] sel;
      assign sel = {sin_w[6*g], sin_w[6*g+5], sin_w[6*g+1 +: 4]};
      assign s_w[4*g +: 4] = 4'(SBOX[g][sel]);
   end

   for (genvar g = 0; g < 32; g++) begin : g_p
      assign p_w[g] = s_w[P_T[g]-1];
   end

   assign round_d = {state_q[32:63], state_q[0:31] ^ p_w};
   assign swap_w  = {round_d[32:63], round_d[0:31]};

   for (genvar g = 0; g < 64; g++) begin : g_fp
      assign fp_w[g] = swap_w[FP_T[g]-1];
   end

`ifdef DES_DONE_EN
   logic done_q;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         round_idx_q <= '0;
         state_q     <= '0;
         key_q       <= '0;
         dout_q      <= '0;
`ifdef DES_DONE_EN
         done_q      <= 1'b0;
`endif
      end else begin
`ifdef DES_DONE_EN
         done_q <= (round_idx_q == 5'd16);
`endif
         if (round_idx_q == 5'd0) begin
            state_q     <= ip_w;
            key_q       <= pc1_w;
            round_idx_q <= 5'd1;
         end else begin
            state_q <= round_d;
            key_q   <= next_key_w;
            if (round_idx_q == 5'd16) begin
               dout_q      <= fp_w;
               round_idx_q <= 5'd0;
            end else begin
               round_idx_q <= round_idx_q + 5'd1;
            end
         end
      end
   end

   assign DOUT            = dout_q;
   assign round_in        = state_q;
   assign curr_key        = key_q;
   assign next_key        = next_key_w;
   assign round_key       = round_key_w;
   assign shift_out       = shift_w;
   assign round_index_out = round_idx_q;
`ifdef DES_DONE_EN
   assign done            = done_q;
`endif

endmodule

// File: tb/tb_des_core.sv
// Directed-vector bench for des_core: known-answer blocks, key schedule, input hold,
// asynchronous mid-block reset and back-to-back operation.
module tb_des_core;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [0:63] DIN = '0;
   logic [0:63] key = '0;
   logic [0:63] DOUT;
   logic [0:63] round_in;
   logic [0:55] curr_key;
   logic [0:55] next_key;
   logic [0:47] round_key;
   logic        shift_out;
   logic [4:0]  round_index_out;
`ifdef DES_DONE_EN
   logic        done;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   des_core u_dut (
      .clock(clock),
      .reset_n(reset_n),
      .DIN(DIN),
      .key(key),
      .DOUT(DOUT),
      .round_in(round_in),
      .curr_key(curr_key),
      .next_key(next_key),
      .round_key(round_key),
      .shift_out(shift_out),
`ifdef DES_DONE_EN
      .done(done),
`endif
      .round_index_out(round_index_out)
   );

   typedef struct {
      logic [63:0] din;
      logic [63:0] key;
      logic [55:0] pc1;
      logic [47:0] k1;
      logic [47:0] k16;
      logic [63:0] dout;
   } vec_t;

   vec_t vecs [4];
   logic [1:16] shift_exp = 16'b1100_0000_1000_0001;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_idx(input logic [4:0] target);
      int k = 0;
      while (round_index_out !== target && k < 40) begin
         @(negedge clock);
         k++;
      end
      if (round_index_out !== target) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_idx: round_index %0d never reached %0d", round_index_out, target);
      end
   endtask

   initial begin
      vecs[0] = '{64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 56'hF0CCAAF556678F,
                  48'h1B02EFFC7072, 48'hCB3D8B0E17F5, 64'h85E813540F0AB405};
      vecs[1] = '{64'h123456ABCD132536, 64'hAABB09182736CCDD, 56'hC3C033A33F0CFA,
                  48'h194CD072DE8C, 48'h181C5D75C66D, 64'hC0B7A8D05F3A829C};
      vecs[2] = '{64'h0, 64'h0, 56'h0, 48'h0, 48'h0, 64'h8CA64DE9C1B123A7};
      vecs[3] = '{64'h0, 64'h0101010101010101, 56'h0, 48'h0, 48'h0, 64'h8CA64DE9C1B123A7};

      DIN = vecs[0].din;
      key = vecs[0].key;

      // Reset state
      repeat (2) @(negedge clock);
      chk("rst_dout", DOUT, 64'h0);
      chk("rst_round_in", round_in, 64'h0);
      chk("rst_curr_key", curr_key, 64'h0);
      chk("rst_index", round_index_out, 64'h0);
      chk("rst_shift", shift_out, 64'h0);
      reset_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         wait_idx(5'd0);
         @(negedge clock);
         chk($sformatf("v%0d_load_index", i), round_index_out, 64'd1);
         chk($sformatf("v%0d_load_key", i), curr_key, vecs[i].pc1);
         chk($sformatf("v%0d_k1", i), round_key, vecs[i].k1);
         if (i == 0)
            chk("v0_next_key_r1", next_key, 56'hE19955FAACCF1E);
         for (int r = 1; r <= 16; r++) begin
            chk($sformatf("v%0d_index_r%0d", i, r), round_index_out, 64'(r));
            chk($sformatf("v%0d_shift_r%0d", i, r), shift_out, 64'(shift_exp[r]));
            if (r == 16)
               chk($sformatf("v%0d_k16", i), round_key, vecs[i].k16);
            if (r == 5) begin
               DIN = (i < 3) ? vecs[i+1].din : vecs[0].din;
               key = (i < 3) ? vecs[i+1].key : vecs[0].key;
            end
            @(negedge clock);
         end
         chk($sformatf("v%0d_wrap_index", i), round_index_out, 64'd0);
         chk($sformatf("v%0d_dout", i), DOUT, vecs[i].dout);
         chk($sformatf("v%0d_key_restored", i), curr_key, vecs[i].pc1);
      end

      // Block with vecs[0] inputs is now loading; let it finish, then check steady state.
      repeat (17) @(negedge clock);
      for (int c = 0; c < 34; c++) begin
         chk($sformatf("b2b_index_c%0d", c), round_index_out, 64'(c % 17));
         chk($sformatf("b2b_dout_c%0d", c), DOUT, vecs[0].dout);
`ifdef DES_DONE_EN
         chk($sformatf("b2b_done_c%0d", c), done, 64'((c % 17) == 0));
`endif
         @(negedge clock);
      end

      // Asynchronous reset mid-block
      wait_idx(5'd7);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_dout", DOUT, 64'h0);
      chk("mid_rst_round_in", round_in, 64'h0);
      chk("mid_rst_curr_key", curr_key, 64'h0);
      chk("mid_rst_index", round_index_out, 64'h0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("post_rst_index", round_index_out, 64'd1);
      chk("post_rst_key", curr_key, vecs[0].pc1);
      chk("post_rst_dout_held", DOUT, 64'h0);
`ifdef DES_DONE_EN
      chk("post_rst_done", done, 64'd0);
`endif
      wait_idx(5'd0);
      chk("post_rst_block_dout", DOUT, vecs[0].dout);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
